// File: rtl/mips_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mips_pkg : opcode/funct encodings, reset vector, register indices, byte swap
// Revision : 1.0
// ---------------------------------------------------------------------------
package mips_pkg;

  localparam logic [31:0] c_RESET_VECTOR = 32'hBFC0_0000;

  localparam logic [4:0] c_REG_ZERO = 5'd0;
  localparam logic [4:0] c_REG_V0   = 5'd2;
  localparam logic [4:0] c_REG_RA   = 5'd31;

  typedef enum logic [5:0] {
    OP_SPECIAL = 6'h00,
    OP_J       = 6'h02,
    OP_JAL     = 6'h03,
    OP_BEQ     = 6'h04,
    OP_BNE     = 6'h05,
    OP_ADDIU   = 6'h09,
    OP_ANDI    = 6'h0C,
    OP_ORI     = 6'h0D,
    OP_XORI    = 6'h0E,
    OP_LUI     = 6'h0F,
    OP_LW      = 6'h23,
    OP_SW      = 6'h2B
  } opcode_e;

  typedef enum logic [5:0] {
    FN_SLL  = 6'h00,
    FN_SRL  = 6'h02,
    FN_SRA  = 6'h03,
    FN_JR   = 6'h08,
    FN_ADDU = 6'h21,
    FN_SUBU = 6'h23,
    FN_AND  = 6'h24,
    FN_OR   = 6'h25,
    FN_XOR  = 6'h26,
    FN_SLT  = 6'h2A,
    FN_SLTU = 6'h2B
  } funct_e;

  function automatic logic [31:0] byteswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/mips_regfile.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mips_regfile : 32x32 GPR file, two async read ports, one sync write port
// Revision     : 1.0
// ---------------------------------------------------------------------------
module mips_regfile
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr_a,
  input  logic [4:0]  raddr_b,
  output logic [31:0] rdata_a,
  output logic [31:0] rdata_b,
  output logic [31:0] rdata_v0
);

  logic [31:0] r_regs [32];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (we && (waddr != c_REG_ZERO)) begin
      r_regs[waddr] <= wdata;
    end
  end

  assign rdata_a  = (raddr_a == c_REG_ZERO) ? 32'h0 : r_regs[raddr_a];
  assign rdata_b  = (raddr_b == c_REG_ZERO) ? 32'h0 : r_regs[raddr_b];
  assign rdata_v0 = r_regs[c_REG_V0];

endmodule
`default_nettype wire

// File: rtl/mips_harvard_cpu.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mips_harvard_cpu : single-cycle MIPS I subset, Harvard buses, one delay slot
// Optional trace output with MIPS_CPU_TRACE_EN.   Revision : 1.0
// ---------------------------------------------------------------------------
module mips_harvard_cpu
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = c_RESET_VECTOR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  output logic        active,
  output logic [31:0] register_v0,
  output logic [31:0] instr_address,
  input  logic [31:0] instr_readdata,
  output logic [31:0] data_address,
  output logic        data_write,
  output logic        data_read,
  output logic [31:0] data_writedata,
  input  logic [31:0] data_readdata
);

  logic [31:0] r_pc, r_npc;
  logic        r_active;

  logic [31:0] w_instr, w_rs_val, w_rt_val, w_imm_sext, w_imm_zext;
  logic [31:0] w_pc_plus4, w_ea, w_wb_data, w_next_npc;
  logic [5:0]  w_op, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd, w_shamt, w_wb_addr;
  logic [15:0] w_imm;
  logic [25:0] w_target;
  logic        w_run, w_exec, w_wb_en, w_is_lw, w_is_sw;

  assign w_instr    = byteswap(instr_readdata);
  assign w_op       = w_instr[31:26];
  assign w_rs       = w_instr[25:21];
  assign w_rt       = w_instr[20:16];
  assign w_rd       = w_instr[15:11];
  assign w_shamt    = w_instr[10:6];
  assign w_funct    = w_instr[5:0];
  assign w_imm      = w_instr[15:0];
  assign w_target   = w_instr[25:0];
  assign w_imm_sext = {{16{w_imm[15]}}, w_imm};
  assign w_imm_zext = {16'h0, w_imm};
  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_ea       = w_rs_val + w_imm_sext;

  // Bus strobes are suppressed in reset and after halt; writes also need clk_enable.
  assign w_run = reset && r_active;
  assign w_exec = w_run && clk_enable;

  mips_regfile u_regfile (
    .clk      (clk),
    .reset    (reset),
    .we       (w_exec && w_wb_en),
    .waddr    (w_wb_addr),
    .wdata    (w_wb_data),
    .raddr_a  (w_rs),
    .raddr_b  (w_rt),
    .rdata_a  (w_rs_val),
    .rdata_b  (w_rt_val),
    .rdata_v0 (register_v0)
  );

  always_comb begin
    w_wb_en    = 1'b0;
    w_wb_addr  = w_rt;
    w_wb_data  = 32'h0;
    w_is_lw    = 1'b0;
    w_is_sw    = 1'b0;
    w_next_npc = r_npc + 32'd4;
    case (w_op)
      OP_SPECIAL: begin
        w_wb_en   = 1'b1;
        w_wb_addr = w_rd;
        case (w_funct)
          FN_SLL:  w_wb_data = w_rt_val << w_shamt;
          FN_SRL:  w_wb_data = w_rt_val >> w_shamt;
          FN_SRA:  w_wb_data = $signed(w_rt_val) >>> w_shamt;
          FN_ADDU: w_wb_data = w_rs_val + w_rt_val;
          FN_SUBU: w_wb_data = w_rs_val - w_rt_val;
          FN_AND:  w_wb_data = w_rs_val & w_rt_val;
          FN_OR:   w_wb_data = w_rs_val | w_rt_val;
          FN_XOR:  w_wb_data = w_rs_val ^ w_rt_val;
          FN_SLT:  w_wb_data = {31'h0, $signed(w_rs_val) < $signed(w_rt_val)};
          FN_SLTU: w_wb_data = {31'h0, w_rs_val < w_rt_val};
          FN_JR: begin
            w_wb_en    = 1'b0;
            w_next_npc = w_rs_val;
          end
          default: w_wb_en = 1'b0;
        endcase
      end
      OP_J:   w_next_npc = {w_pc_plus4[31:28], w_target, 2'b00};
      OP_JAL: begin
        w_next_npc = {w_pc_plus4[31:28], w_target, 2'b00};
        w_wb_en    = 1'b1;
        w_wb_addr  = c_REG_RA;
        w_wb_data  = r_pc + 32'd8;
      end
      OP_BEQ: if (w_rs_val == w_rt_val) w_next_npc = w_pc_plus4 + {w_imm_sext[29:0], 2'b00};
      OP_BNE: if (w_rs_val != w_rt_val) w_next_npc = w_pc_plus4 + {w_imm_sext[29:0], 2'b00};
      OP_ADDIU: begin w_wb_en = 1'b1; w_wb_data = w_rs_val + w_imm_sext; end
      OP_ANDI:  begin w_wb_en = 1'b1; w_wb_data = w_rs_val & w_imm_zext; end
      OP_ORI:   begin w_wb_en = 1'b1; w_wb_data = w_rs_val | w_imm_zext; end
      OP_XORI:  begin w_wb_en = 1'b1; w_wb_data = w_rs_val ^ w_imm_zext; end
      OP_LUI:   begin w_wb_en = 1'b1; w_wb_data = {w_imm, 16'h0}; end
      OP_LW: begin
        w_is_lw   = 1'b1;
        w_wb_en   = 1'b1;
        w_wb_data = byteswap(data_readdata);
      end
      OP_SW:   w_is_sw = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc     <= RESET_VECTOR;
      r_npc    <= RESET_VECTOR + 32'd4;
      r_active <= 1'b1;
    end else if (clk_enable && r_active) begin
      r_pc  <= r_npc;
      r_npc <= w_next_npc;
      if (r_npc == 32'h0) r_active <= 1'b0;
    end
  end

  assign active         = r_active;
  assign instr_address  = r_pc;
  assign data_address   = w_ea & 32'hFFFF_FFFC;
  assign data_read      = w_run && w_is_lw;
  assign data_write     = w_exec && w_is_sw;
  assign data_writedata = (w_run && w_is_sw) ? byteswap(w_rt_val) : 32'h0;

`ifdef MIPS_CPU_TRACE_EN
  always @(posedge clk) begin
    if (w_exec) begin
      $display("trace: pc=%h instr=%h", r_pc, w_instr);
      if (w_wb_en && (w_wb_addr != c_REG_ZERO))
        $display("trace:   r%0d <= %h", w_wb_addr, w_wb_data);
      if (w_is_sw)
        $display("trace:   mem[%h] <= %h", data_address, w_rt_val);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mips_harvard_cpu.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mips_harvard_cpu : directed programs with hand-computed expectations
// Revision : 1.0
// ---------------------------------------------------------------------------
module tb_mips_harvard_cpu;

  logic        clk = 1'b0;
  logic        reset, clk_enable, active, data_write, data_read;
  logic [31:0] register_v0, instr_address, instr_readdata;
  logic [31:0] data_address, data_writedata, data_readdata;

  logic [31:0] rom [64];
  logic [31:0] ram [1024];
  logic [31:0] rom_off;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  mips_harvard_cpu dut (
    .clk            (clk),
    .reset          (reset),
    .clk_enable     (clk_enable),
    .active         (active),
    .register_v0    (register_v0),
    .instr_address  (instr_address),
    .instr_readdata (instr_readdata),
    .data_address   (data_address),
    .data_write     (data_write),
    .data_read      (data_read),
    .data_writedata (data_writedata),
    .data_readdata  (data_readdata)
  );

  function automatic logic [31:0] swap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // ROM is stored in CPU byte order and presented byte-reversed on the bus.
  assign rom_off        = instr_address - 32'hBFC0_0000;
  assign instr_readdata = (rom_off < 32'd256) ? swap32(rom[rom_off[7:2]]) : 32'h0;
  assign data_readdata  = ram[data_address[11:2]];

  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 32'h0;
    end else if (data_write) begin
      ram[data_address[11:2]] <= data_writedata;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] expv;
    int          cycles;

    // Program 1: build constants, store 14 running sums, halt via jr $0.
    reset = 1'b0;
    clk_enable = 1'b1;
    for (int i = 0; i < 64; i++) rom[i] = 32'h0;
    rom[0] = enc_i(6'h0F, 5'd0, 5'd1, 16'h1234);
    rom[1] = enc_i(6'h0D, 5'd1, 5'd1, 16'h5678);
    rom[2] = enc_i(6'h0F, 5'd0, 5'd3, 16'hDCBA);
    rom[3] = enc_i(6'h0D, 5'd3, 5'd3, 16'h1234);
    rom[4] = enc_i(6'h09, 5'd0, 5'd4, 16'h0100);
    for (int k = 0; k < 14; k++) begin
      rom[5 + 3*k] = enc_i(6'h2B, 5'd4, 5'd1, 16'h0000);
      rom[6 + 3*k] = enc_r(6'h21, 5'd1, 5'd3, 5'd1);
      rom[7 + 3*k] = enc_i(6'h09, 5'd4, 5'd4, 16'h0004);
    end
    rom[47] = enc_r(6'h08, 5'd0, 5'd0, 5'd0);
    rom[48] = 32'h0;

    step();
    check("reset_pc", instr_address, 32'hBFC0_0000);
    check("reset_active", {31'h0, active}, 32'h1);
    check("reset_v0", register_v0, 32'h0);
    check("reset_dwrite", {31'h0, data_write}, 32'h0);
    check("reset_dread", {31'h0, data_read}, 32'h0);
    reset = 1'b1;

    cycles = 0;
    while (active && cycles < 200) begin
      step();
      cycles++;
    end
    check("halt_cycles", cycles, 49);
    check("halt_pc", instr_address, 32'h0);
    check("halt_active", {31'h0, active}, 32'h0);
    expv = 32'h1234_5678;
    for (int k = 0; k < 14; k++) begin
      check($sformatf("store_w%0d", k), ram[64 + k], swap32(expv));
      expv = expv + 32'hDCBA_1234;
    end

    // Program 2: LW round trip, delay slot, $zero, JAL, clk_enable freeze.
    reset = 1'b0;
    for (int i = 0; i < 64; i++) rom[i] = 32'h0;
    rom[0]  = enc_i(6'h0F, 5'd0, 5'd5, 16'hCAFE);
    rom[1]  = enc_i(6'h0D, 5'd5, 5'd5, 16'hF00D);
    rom[2]  = enc_i(6'h2B, 5'd0, 5'd5, 16'h0200);
    rom[3]  = enc_i(6'h23, 5'd0, 5'd2, 16'h0200);
    rom[4]  = enc_i(6'h04, 5'd0, 5'd0, 16'h0002);
    rom[5]  = enc_i(6'h09, 5'd0, 5'd2, 16'd5);
    rom[6]  = enc_i(6'h09, 5'd0, 5'd2, 16'd99);
    rom[7]  = enc_i(6'h09, 5'd0, 5'd0, 16'd7);
    rom[8]  = enc_r(6'h21, 5'd0, 5'd0, 5'd2);
    rom[9]  = {6'h03, 26'h3F0_000C};
    rom[10] = enc_r(6'h21, 5'd31, 5'd0, 5'd2);
    rom[11] = enc_i(6'h09, 5'd0, 5'd2, 16'd99);
    rom[12] = enc_i(6'h09, 5'd2, 5'd2, 16'd1);
    rom[13] = enc_i(6'h2B, 5'd0, 5'd2, 16'h0300);
    rom[14] = enc_i(6'h09, 5'd2, 5'd2, 16'd1);
    rom[15] = enc_r(6'h08, 5'd0, 5'd0, 5'd0);
    rom[16] = 32'h0;
    step();
    check("reset2_pc", instr_address, 32'hBFC0_0000);
    check("reset2_v0", register_v0, 32'h0);
    check("reset2_active", {31'h0, active}, 32'h1);
    reset = 1'b1;

    step();
    step();
    check("sw_write", {31'h0, data_write}, 32'h1);
    check("sw_read", {31'h0, data_read}, 32'h0);
    check("sw_addr", data_address, 32'h0000_0200);
    check("sw_data", data_writedata, 32'h0DF0_FECA);
    step();
    check("lw_read", {31'h0, data_read}, 32'h1);
    check("lw_write", {31'h0, data_write}, 32'h0);
    check("lw_addr", data_address, 32'h0000_0200);
    check("ram_200", ram[128], 32'h0DF0_FECA);
    step();
    check("lw_v0", register_v0, 32'hCAFE_F00D);
    check("beq_read", {31'h0, data_read}, 32'h0);
    step();
    step();
    check("slot_v0", register_v0, 32'd5);
    check("branch_pc", instr_address, 32'hBFC0_001C);
    step();
    step();
    check("zero_reg", register_v0, 32'h0);
    step();
    check("jal_slot_pc", instr_address, 32'hBFC0_0028);
    step();
    check("jal_ra", register_v0, 32'hBFC0_002C);
    check("jal_target_pc", instr_address, 32'hBFC0_0030);
    step();
    check("pre_freeze_v0", register_v0, 32'hBFC0_002D);
    check("pre_freeze_pc", instr_address, 32'hBFC0_0034);

    clk_enable = 1'b0;
    #1;
    check("freeze_dwrite", {31'h0, data_write}, 32'h0);
    repeat (5) step();
    check("freeze_pc", instr_address, 32'hBFC0_0034);
    check("freeze_v0", register_v0, 32'hBFC0_002D);
    check("freeze_ram", ram[192], 32'h0);
    check("freeze_active", {31'h0, active}, 32'h1);
    clk_enable = 1'b1;
    #1;
    check("resume_dwrite", {31'h0, data_write}, 32'h1);
    step();
    check("resume_ram", ram[192], 32'h2D00_C0BF);
    step();
    check("resume_v0", register_v0, 32'hBFC0_002E);
    step();
    step();
    check("halt2_active", {31'h0, active}, 32'h0);
    check("halt2_pc", instr_address, 32'h0);
    check("halt2_wdata", data_writedata, 32'h0);
    repeat (3) step();
    check("halted_pc", instr_address, 32'h0);
    check("halted_v0", register_v0, 32'hBFC0_002E);
    check("halted_dwrite", {31'h0, data_write}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mips_harvard_cpu.md
Name: mips_harvard_cpu

Overview:
Single-cycle, 32-bit MIPS I subset CPU with separate instruction and data buses (Harvard).
- Instruction fetch and data read are combinational; data write completes in one cycle.
- Sits between an instruction ROM and a data RAM.
- Exposes `register_v0` and an `active` flag so the bench can observe execution and end-of-program.

Parameters:
- `RESET_VECTOR`, 32'hBFC00000, PC value loaded on reset.

Ports:
- `clk`  in  1  system clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-low reset (asserted when 0)
- `clk_enable`  in  1  1 = advance one instruction per cycle; 0 = freeze all state
- `active`  out  1  1 while the program runs; 0 once halted
- `register_v0`  out  32  current contents of GPR 2, combinational
- `instr_address`  out  32  byte address of the fetched instruction (= PC)
- `instr_readdata`  in  32  instruction word, valid in the same cycle
- `data_address`  out  32  byte address of the load/store; low 2 bits forced to 0
- `data_write`  out  1  1 during an SW cycle; RAM writes on that rising edge
- `data_read`  out  1  1 during an LW cycle
- `data_writedata`  out  32  store data
- `data_readdata`  in  32  load data, valid in the same cycle

Behaviour:
- **Reset** (rising edge with `reset`=0, regardless of `clk_enable`):
  - PC = `RESET_VECTOR`, nPC = `RESET_VECTOR`+4.
  - All 32 GPRs = 0; `active` = 1.
- **Outputs during reset and while `active`=0:** `data_read`=0, `data_write`=0, `data_writedata`=0.
- **Byte order:** both buses are byte-reversed relative to the CPU.
  - Bus bits [7:0] hold the CPU's most-significant byte.
  - The CPU byte-swaps `instr_readdata` and `data_readdata` on input, and `data_writedata` on output.
  - Consequence: a stored value V appears on the RAM word as `byteswap(V)`.
- **Execution:** one instruction per enabled cycle; no stalls; results are written at the rising edge.
  - A following instruction, including one after LW, sees the new value; there is no load-delay hazard.
- **Register 0:** reads as 0; writes are discarded.
- **Supported instructions:**
  - ALU register: ADDU, SUBU, AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA.
  - ALU immediate: ADDIU, ANDI, ORI, XORI, LUI.
  - Memory: LW, SW.
  - Control: BEQ, BNE, J, JAL, JR.
- **Immediates:** sign-extended for ADDIU, LW, SW and branches; zero-extended for ANDI, ORI and XORI.
- **Arithmetic:** ADDU, SUBU and ADDIU are modulo 2^32 and never trap. SLT is signed; SLTU is unsigned.
- **Effective address:** LW/SW address = rs + sext(imm16).
- **Control flow, one delay slot:**
  - PC register and nPC register; each enabled cycle PC <= nPC.
  - nPC <= target if taken, else nPC+4.
  - Branch target = PC+4 + (sext(imm)<<2).
  - J/JAL target = {PC+4[31:28], imm26, 2'b00}.
  - JAL writes PC+8 to r31.
- **Undefined opcodes:** executed as NOP.
- **Halt:**
  - When PC becomes 32'h00000000 (normally after `jr $0` and its delay slot), `active` <= 0 on that edge.
  - The instruction at address 0 is never executed; state is frozen until reset.
- **`clk_enable`=0:** PC, nPC, GPRs and `active` hold; `data_write` is forced to 0.
- **Simultaneous events:** reset has priority over `clk_enable` and over halt.

Optional Feature:
- `MIPS_CPU_TRACE_EN`: when defined, every executed instruction prints PC, instruction word and any register or memory write.
- Without it, the block is purely synthesizable with no simulation output.
- Architectural behaviour is identical either way.

Decomposition:
- Package `mips_pkg`:
  - opcode and funct enumerations;
  - `RESET_VECTOR` default;
  - byte-swap function;
  - register index constants (ZERO=0, V0=2, RA=31).
- Sub-module `mips_regfile`:
  - 32x32 register file;
  - two combinational read ports, one synchronous write port;
  - synchronous active-low clear;
  - extra read tap for r2.

Test Plan:
- **Reset:** hold `reset`=0 for one edge.
  - `instr_address`=BFC00000, `active`=1, `register_v0`=0, `data_write`=0.
- **Store sequence:** LUI/ORI build 12345678, then ADDU repeatedly adds DCBA1234 and SW stores at 0x100, 0x104, … for 14 words, then `jr $0`.
  - Byte-swapped RAM word k = 12345678 + k*DCBA1234 (mod 2^32).
  - `active` falls after the delay slot.
- **LW round trip:** SW 0xCAFEF00D to 0x200, LW it into $v0 in the next instruction.
  - `register_v0` = CAFEF00D; `data_read`=1 only during the LW cycle.
- **Delay slot:** BEQ taken followed by ADDIU $2,$0,5.
  - `register_v0`=5; target instruction executes next.
  - Fall-through instruction is skipped.
- **`clk_enable` low:** drop `clk_enable` for 5 cycles mid-program.
  - `instr_address` and `register_v0` unchanged; no data writes; resumes correctly.
- **$zero and JAL:** ADDIU $0,$0,7 then JAL.
  - $0 reads 0; r31 = JAL PC+8.
